int_div_dispatch: RTL

- Initiator-side front end for the shared iterative integer divider of the APU cluster.
- Arbitrates divide/remainder requests from NCORES cores using round-robin arbitration.
- Issues one operation at a time to the divider, using the core index as the tag.
- Routes each returned result to the originating core as a one-cycle valid pulse.

---
 rtl/int_div_dispatch_if.sv | 41 ++++
 rtl/int_div_dispatch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/int_div_dispatch_if.sv
// Bundle of core-side and divider-side signals for the shared-divider dispatcher.
// The slave modport is the dispatcher's view; the master modport is the surrounding cores plus divider.
interface int_div_dispatch_if #(
    parameter int NCORES    = 4,
    parameter int TAG_WIDTH = 2
);
    logic [NCORES-1:0]    core_req_i;
    logic [3*NCORES-1:0]  core_op_i;
    logic [32*NCORES-1:0] core_opa_i;
    logic [32*NCORES-1:0] core_opb_i;
    logic [NCORES-1:0]    core_gnt_o;
    logic [NCORES-1:0]    core_rvalid_o;
    logic [31:0]          core_rdata_o;
    logic                 div_en_o;
    logic [2:0]           div_op_o;
    logic [31:0]          div_opa_o;
    logic [31:0]          div_opb_o;
    logic [TAG_WIDTH-1:0] div_tag_o;
    logic                 div_ready_i;
    logic                 div_valid_i;
    logic [31:0]          div_res_i;
    logic [TAG_WIDTH-1:0] div_tag_i;
    logic                 busy_o;
    logic                 tag_err_o;

    modport master (
        output core_req_i, core_op_i, core_opa_i, core_opb_i,
        output div_ready_i, div_valid_i, div_res_i, div_tag_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        input  div_en_o, div_op_o, div_opa_o, div_opb_o, div_tag_o,
        input  busy_o, tag_err_o
    );

    modport slave (
        input  core_req_i, core_op_i, core_opa_i, core_opb_i,
        input  div_ready_i, div_valid_i, div_res_i, div_tag_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        output div_en_o, div_op_o, div_opa_o, div_opb_o, div_tag_o,
        output busy_o, tag_err_o
    );
endinterface

// File: rtl/int_div_dispatch.sv
// Round-robin front end that feeds one shared iterative divider from NCORES cores,
// tagging each issue with the core index and routing the result back as a one-cycle pulse.
module int_div_dispatch #(
    parameter int NCORES    = 4,
    parameter int TAG_WIDTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    int_div_dispatch_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [TAG_WIDTH-1:0] rr_ptr_r;
    logic [TAG_WIDTH-1:0] out_tag_r;
    logic [TAG_WIDTH-1:0] winner_s;
    logic [TAG_WIDTH-1:0] next_ptr_s;
    int                   win_idx_s;
    logic                 issue_s;
    logic [NCORES-1:0]    gnt_s;
    logic                 en_s;
    logic [2:0]           op_s;
    logic [31:0]          opa_s;
    logic [31:0]          opb_s;
    logic [TAG_WIDTH-1:0] tag_s;
    logic [NCORES-1:0]    rvalid_r;
    logic [31:0]          rdata_r;
    logic                 tag_err_r;

    // Cyclic search for the first requester at or above the pointer.
    function automatic logic [TAG_WIDTH-1:0] rr_pick(input logic [NCORES-1:0] req,
                                                     input logic [TAG_WIDTH-1:0] ptr);
        logic [TAG_WIDTH-1:0] win;
        logic                 hit;
        int                   idx;
        win = {TAG_WIDTH{1'b0}};
        hit = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCORES) begin
                idx = idx - NCORES;
            end else begin
                idx = idx;
            end
            if (!hit && req[idx]) begin
                win = TAG_WIDTH'(idx);
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return win;
    endfunction

    // Arbitration winner and the pointer value that follows it.
    always_comb begin
        winner_s  = rr_pick(bus.core_req_i, rr_ptr_r);
        win_idx_s = int'(winner_s);
        if (win_idx_s == NCORES - 1) begin
            next_ptr_s = {TAG_WIDTH{1'b0}};
        end else begin
            next_ptr_s = winner_s + TAG_WIDTH'(1);
        end
    end

    // Next-state decode and combinational issue/grant outputs.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        gnt_s   = {NCORES{1'b0}};
        en_s    = 1'b0;
        op_s    = 3'b000;
        opa_s   = 32'h0000_0000;
        opb_s   = 32'h0000_0000;
        tag_s   = {TAG_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if ((|bus.core_req_i) && bus.div_ready_i) begin
                    issue_s           = 1'b1;
                    en_s              = 1'b1;
                    gnt_s[win_idx_s]  = 1'b1;
                    op_s              = bus.core_op_i[win_idx_s*3 +: 3];
                    opa_s             = bus.core_opa_i[win_idx_s*32 +: 32];
                    opb_s             = bus.core_opb_i[win_idx_s*32 +: 32];
                    tag_s             = winner_s;
                    state_s           = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (bus.div_valid_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, round-robin pointer and outstanding tag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            rr_ptr_r  <= {TAG_WIDTH{1'b0}};
            out_tag_r <= {TAG_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (issue_s) begin
                out_tag_r <= winner_s;
                rr_ptr_r  <= next_ptr_s;
            end
        end
    end

    // Result return path; a result seen outside WAIT is dropped entirely.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_r  <= {NCORES{1'b0}};
            rdata_r   <= 32'h0000_0000;
            tag_err_r <= 1'b0;
        end else begin
            rvalid_r <= {NCORES{1'b0}};
            if ((state_r == WAIT) && bus.div_valid_i) begin
                rvalid_r <= {{(NCORES-1){1'b0}}, 1'b1} << out_tag_r;
                rdata_r  <= bus.div_res_i;
                if (bus.div_tag_i != out_tag_r) begin
                    tag_err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.core_gnt_o    = gnt_s;
    assign bus.div_en_o      = en_s;
    assign bus.div_op_o      = op_s;
    assign bus.div_opa_o     = opa_s;
    assign bus.div_opb_o     = opb_s;
    assign bus.div_tag_o     = tag_s;
    assign bus.core_rvalid_o = rvalid_r;
    assign bus.core_rdata_o  = rdata_r;
    assign bus.tag_err_o     = tag_err_r;
    assign bus.busy_o        = (state_r == WAIT);

endmodule
